// File: rtl/rotor_stepper_pkg.sv
// rotor_stepper_pkg: shared Enigma rotor constants, FSM encoding and load-range helper
package rotor_stepper_pkg;
  localparam int POS_W = 5;
  localparam logic [POS_W-1:0] ALPHABET = 5'd26;
  localparam logic [POS_W-1:0] NOTCH_I = 5'd16;
  localparam logic [POS_W-1:0] NOTCH_II = 5'd4;
  localparam logic [POS_W-1:0] NOTCH_III = 5'd21;
  localparam logic [POS_W-1:0] NOTCH_IV = 5'd9;
  localparam logic [POS_W-1:0] NOTCH_V = 5'd25;
  localparam logic [POS_W-1:0] NOTCH_R = NOTCH_III;
  localparam logic [POS_W-1:0] NOTCH_M = NOTCH_II;
  localparam logic [POS_W-1:0] NOTCH_L = NOTCH_I;
  typedef enum logic [1:0] {S_IDLE, S_ADVANCE, S_DONE} state_t;
  function automatic logic in_range(input logic [7:0] v);
    return v < {3'b000, ALPHABET};
  endfunction
endpackage

// File: rtl/rotor_stepper_counter.sv
// rotor_stepper_counter: mod-ALPHABET rotor position with sync load/enable and notch flag
// ports: clk, rst (async, active-high), load_i/d_i (load value), en_i (advance by one),
//        q_o (position), at_notch_o (q_o == NOTCH)
module rotor_stepper_counter
  import rotor_stepper_pkg::*;
#(
  parameter logic [POS_W-1:0] NOTCH = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [POS_W-1:0] d_i,
  output logic [POS_W-1:0] q_o,
  output logic             at_notch_o
);
  logic [POS_W-1:0] pos_q, pos_d;
  always_comb pos_d = load_i ? d_i : en_i ? (pos_q == ALPHABET - 5'd1 ? '0 : pos_q + 5'd1) : pos_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) pos_q <= '0;
    else pos_q <= pos_d;
  assign q_o = pos_q;
  assign at_notch_o = pos_q == NOTCH;
endmodule

// File: rtl/rotor_stepper.sv
// rotor_stepper: left/middle/right rotor offsets with odometer stepping and double-step
// ports: clk, reset (async, active-high), step/load requests (taken only while ready),
//        pos_in_l/m/r start positions, pos_l/m/r current positions (zero-extended),
//        ready (IDLE), pos_valid (positions just advanced), load_err (load rejected)
module rotor_stepper
  import rotor_stepper_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic       load,
  input  logic [7:0] pos_in_l,
  input  logic [7:0] pos_in_m,
  input  logic [7:0] pos_in_r,
  output logic [7:0] pos_l,
  output logic [7:0] pos_m,
  output logic [7:0] pos_r,
  output logic       ready,
  output logic       pos_valid,
  output logic       load_err
);
  state_t state_q, state_d;
  logic load_err_q, load_err_d;
  logic idle, adv, load_ok;
  logic at_r, at_m, unused_at_notch_l;
  logic [POS_W-1:0] q_l, q_m, q_r;
  assign idle = state_q == S_IDLE;
  assign adv = state_q == S_ADVANCE;
  assign load_ok = idle && load && in_range(pos_in_l) && in_range(pos_in_m) && in_range(pos_in_r);
  always_comb begin
    state_d = idle ? ((step && !load) ? S_ADVANCE : S_IDLE) : adv ? S_DONE : S_IDLE;
    load_err_d = idle && load && !load_ok;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      load_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      load_err_q <= load_err_d;
    end
  // middle steps on right turnover or on its own notch (double-step); left follows middle notch
  rotor_stepper_counter #(.NOTCH(NOTCH_L)) u_l (
    .clk(clk), .rst(reset), .load_i(load_ok), .en_i(adv && at_m),
    .d_i(pos_in_l[POS_W-1:0]), .q_o(q_l), .at_notch_o(unused_at_notch_l)
  );
  rotor_stepper_counter #(.NOTCH(NOTCH_M)) u_m (
    .clk(clk), .rst(reset), .load_i(load_ok), .en_i(adv && (at_r || at_m)),
    .d_i(pos_in_m[POS_W-1:0]), .q_o(q_m), .at_notch_o(at_m)
  );
  rotor_stepper_counter #(.NOTCH(NOTCH_R)) u_r (
    .clk(clk), .rst(reset), .load_i(load_ok), .en_i(adv),
    .d_i(pos_in_r[POS_W-1:0]), .q_o(q_r), .at_notch_o(at_r)
  );
  assign pos_l = {3'b000, q_l};
  assign pos_m = {3'b000, q_m};
  assign pos_r = {3'b000, q_r};
  assign ready = idle;
  assign pos_valid = state_q == S_DONE;
  assign load_err = load_err_q;
endmodule

// File: tb/tb_rotor_stepper.sv
// tb_rotor_stepper: directed and random checks of rotor_stepper against an arithmetic model
module tb_rotor_stepper;
  logic clk = 1'b0, reset = 1'b1, step = 1'b0, load = 1'b0;
  logic [7:0] pos_in_l = '0, pos_in_m = '0, pos_in_r = '0;
  logic [7:0] pos_l, pos_m, pos_r;
  logic ready, pos_valid, load_err;
  int total = 0, bad = 0;
  int ml = 0, mm = 0, mr = 0, busy = 0;
  bit exp_valid = 0, exp_err = 0;

  rotor_stepper dut (
    .clk(clk), .reset(reset), .step(step), .load(load),
    .pos_in_l(pos_in_l), .pos_in_m(pos_in_m), .pos_in_r(pos_in_r),
    .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r),
    .ready(ready), .pos_valid(pos_valid), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // reference: busy counts the two cycles after an accepted step; positions move on the first
  always @(posedge clk or posedge reset)
    if (reset) begin
      ml = 0; mm = 0; mr = 0; busy = 0; exp_valid = 0; exp_err = 0;
    end else begin
      exp_valid = 0;
      exp_err = 0;
      if (busy == 2) begin
        int nl, nm;
        nl = (mm == 4) ? (ml + 1) % 26 : ml;
        nm = (mr == 21 || mm == 4) ? (mm + 1) % 26 : mm;
        mr = (mr + 1) % 26;
        ml = nl;
        mm = nm;
        busy = 1;
        exp_valid = 1;
      end else if (busy == 1) busy = 0;
      else if (load) begin
        if (pos_in_l < 26 && pos_in_m < 26 && pos_in_r < 26) begin
          ml = int'(pos_in_l); mm = int'(pos_in_m); mr = int'(pos_in_r);
        end else exp_err = 1;
      end else if (step) busy = 2;
    end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (!reset) begin
      check("model_pos_l", int'(pos_l), ml);
      check("model_pos_m", int'(pos_m), mm);
      check("model_pos_r", int'(pos_r), mr);
      check("model_ready", int'(ready), int'(busy == 0));
      check("model_pos_valid", int'(pos_valid), int'(exp_valid));
      check("model_load_err", int'(load_err), int'(exp_err));
    end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_pos(input string name, input int l, input int m, input int r);
    check({name, "_l"}, int'(pos_l), l);
    check({name, "_m"}, int'(pos_m), m);
    check({name, "_r"}, int'(pos_r), r);
  endtask

  task automatic do_load(input int l, input int m, input int r);
    load = 1; pos_in_l = 8'(l); pos_in_m = 8'(m); pos_in_r = 8'(r);
    tick();
    load = 0;
  endtask

  task automatic do_step();
    step = 1;
    tick();
    step = 0;
    check("step_busy", int'(ready), 0);
    tick();
    check("step_valid", int'(pos_valid), 1);
    tick();
    check("step_ready_back", int'(ready), 1);
    check("step_valid_gone", int'(pos_valid), 0);
  endtask

  initial begin
    int pulses;
    repeat (2) tick();
    chk_pos("reset", 0, 0, 0);
    check("reset_ready", int'(ready), 1);
    reset = 0;
    tick();
    do_step();
    chk_pos("single", 0, 0, 1);
    do_load(0, 3, 20);
    chk_pos("load_adu", 0, 3, 20);
    do_step();
    chk_pos("dbl1", 0, 3, 21);
    do_step();
    chk_pos("dbl2", 0, 4, 22);
    do_step();
    chk_pos("dbl3", 1, 5, 23);
    do_load(25, 25, 25);
    do_step();
    chk_pos("wrap", 25, 25, 0);
    load = 1; pos_in_l = 8'd1; pos_in_m = 8'd26; pos_in_r = 8'd1;
    tick();
    load = 0;
    check("rej_err", int'(load_err), 1);
    chk_pos("rej_keep", 25, 25, 0);
    tick();
    check("rej_err_once", int'(load_err), 0);
    check("rej_no_valid", int'(pos_valid), 0);
    // step held across six edges: accepted on the first and fourth only
    pulses = 0;
    step = 1;
    repeat (6) begin
      tick();
      pulses += int'(pos_valid);
    end
    step = 0;
    repeat (3) begin
      tick();
      pulses += int'(pos_valid);
    end
    check("held_pulses", pulses, 2);
    chk_pos("held_pos", 25, 25, 2);
    load = 1; step = 1; pos_in_l = 8'd1; pos_in_m = 8'd2; pos_in_r = 8'd3;
    tick();
    load = 0; step = 0;
    chk_pos("prio", 1, 2, 3);
    check("prio_ready", int'(ready), 1);
    tick();
    check("prio_no_valid", int'(pos_valid), 0);
    step = 1;
    tick();
    step = 0;
    reset = 1;
    #1;
    chk_pos("mid_reset", 0, 0, 0);
    check("mid_reset_ready", int'(ready), 1);
    check("mid_reset_valid", int'(pos_valid), 0);
    tick();
    reset = 0;
    tick();
    check("post_reset_valid", int'(pos_valid), 0);
    chk_pos("post_reset", 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      step = ($urandom_range(0, 3) != 0);
      load = ($urandom_range(0, 9) == 0);
      pos_in_l = 8'($urandom_range(0, 27));
      pos_in_m = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 25));
      pos_in_r = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(18, 24)) : 8'($urandom_range(0, 26));
      if ($urandom_range(0, 199) == 0) begin
        reset = 1;
        tick();
        reset = 0;
      end
      tick();
    end
    step = 0; load = 0;
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
